// File: rtl/vector_lane_issue_stage.sv
// Per-lane operand issue stage: hazard-checks decoded vector instructions against a
// destination scoreboard, reads the register file and hands captured operands to execution.
module vector_lane_issue_stage #(
   parameter int VREG_BITS           = 64,
   parameter int NUMBER_OF_REGISTERS = 32,
   parameter int OP_BITS             = 6,
   localparam int ADDR_W             = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           instr_valid,
   output logic                           instr_ready,
   input  logic [OP_BITS-1:0]             instr_op,
   input  logic [ADDR_W-1:0]              instr_src1,
   input  logic [ADDR_W-1:0]              instr_src2,
   input  logic [ADDR_W-1:0]              instr_src3,
   input  logic                           instr_use_src3,
   input  logic                           instr_masked,
   input  logic [ADDR_W-1:0]              instr_dest,
   output logic [ADDR_W-1:0]              rf_addr_1,
   output logic [ADDR_W-1:0]              rf_addr_2,
   output logic [ADDR_W-1:0]              rf_addr_3,
   input  logic [VREG_BITS-1:0]           rf_data_1,
   input  logic [VREG_BITS-1:0]           rf_data_2,
   input  logic [VREG_BITS-1:0]           rf_data_3,
   input  logic [VREG_BITS-1:0]           rf_mask,
   output logic                           ex_valid,
   input  logic                           ex_ready,
   output logic [OP_BITS-1:0]             ex_op,
   output logic [ADDR_W-1:0]              ex_dest,
   output logic [VREG_BITS-1:0]           ex_operand_1,
   output logic [VREG_BITS-1:0]           ex_operand_2,
   output logic [VREG_BITS-1:0]           ex_operand_3,
   output logic [VREG_BITS-1:0]           ex_mask,
   input  logic                           wb_valid,
   input  logic [ADDR_W-1:0]              wb_dest,
   input  logic                           ld_issue_valid,
   input  logic [ADDR_W-1:0]              ld_issue_dest,
   input  logic                           ld_wb_valid,
   input  logic [ADDR_W-1:0]              ld_wb_dest,
   output logic [NUMBER_OF_REGISTERS-1:0] busy,
   output logic [1:0]                     dbg_state   // 0 = IDLE, 1 = READ, 2 = HOLD
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and ready may depend combinationally on the offered fields.
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_t;

   state_t                         state_q, state_d;
   logic [NUMBER_OF_REGISTERS-1:0] busy_q, busy_d;
   logic [OP_BITS-1:0]             ex_op_q, ex_op_d;
   logic [ADDR_W-1:0]              ex_dest_q, ex_dest_d;
   logic [VREG_BITS-1:0]           opnd_1_q, opnd_1_d, opnd_2_q, opnd_2_d, opnd_3_q, opnd_3_d;
   logic [VREG_BITS-1:0]           mask_q, mask_d;
   logic                           masked_q, masked_d;
   logic                           hazard;
   logic                           accept;

   assign rf_addr_1 = instr_src1;
   assign rf_addr_2 = instr_src2;
   assign rf_addr_3 = instr_src3;

   assign hazard = busy_q[instr_src1] | busy_q[instr_src2]
                 | (instr_use_src3 & busy_q[instr_src3])
                 | (instr_masked & busy_q[0])
                 | busy_q[instr_dest];

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      ex_op_d     = ex_op_q;
      ex_dest_d   = ex_dest_q;
      opnd_1_d    = opnd_1_q;
      opnd_2_d    = opnd_2_q;
      opnd_3_d    = opnd_3_q;
      mask_d      = mask_q;
      masked_d    = masked_q;
      instr_ready = 1'b0;
      ex_valid    = 1'b0;
      accept      = 1'b0;

      case (state_q)
         IDLE: instr_ready = !hazard;
         READ: begin
            // Register file returns data one cycle after the accept edge sampled the addresses.
            opnd_1_d = rf_data_1;
            opnd_2_d = rf_data_2;
            opnd_3_d = rf_data_3;
            mask_d   = masked_q ? rf_mask : '1;
            state_d  = HOLD;
         end
         HOLD: begin
            ex_valid = 1'b1;
            if (ex_ready) begin
               instr_ready = !hazard;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      accept = instr_valid & instr_ready;
      if (accept) begin
         state_d   = READ;
         ex_op_d   = instr_op;
         ex_dest_d = instr_dest;
         masked_d  = instr_masked;
      end

      // Clears first so that a same-cycle set to the same register wins.
      if (wb_valid)       busy_d[wb_dest]       = 1'b0;
      if (ld_wb_valid)    busy_d[ld_wb_dest]    = 1'b0;
      if (ld_issue_valid) busy_d[ld_issue_dest] = 1'b1;
      if (accept)         busy_d[instr_dest]    = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= '0;
         ex_op_q   <= '0;
         ex_dest_q <= '0;
         opnd_1_q  <= '0;
         opnd_2_q  <= '0;
         opnd_3_q  <= '0;
         mask_q    <= '0;
         masked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         ex_op_q   <= ex_op_d;
         ex_dest_q <= ex_dest_d;
         opnd_1_q  <= opnd_1_d;
         opnd_2_q  <= opnd_2_d;
         opnd_3_q  <= opnd_3_d;
         mask_q    <= mask_d;
         masked_q  <= masked_d;
      end
   end

   assign busy         = busy_q;
   assign ex_op        = ex_op_q;
   assign ex_dest      = ex_dest_q;
   assign ex_operand_1 = opnd_1_q;
   assign ex_operand_2 = opnd_2_q;
   assign ex_operand_3 = opnd_3_q;
   assign ex_mask      = mask_q;
   assign dbg_state    = state_q;

endmodule
